stack_unit_arbiter: RTL and testbench

Round-robin arbiter and issue sequencer that shares one stack arithmetic unit between two command requesters. It accepts one command at a time over a valid/ready handshake and checks the stack-depth precondition against the unit's live `cnt`/`out`. It pulses the unit's `en` for exactly one cycle, holds off further issue for the operation's latency, then returns the resulting top-of-stack and depth to the issuing requester. It sits between the command sources and the stack unit; the stack unit is driven only by this block.

---
 rtl/stack_unit_arbiter.sv | 161 ++++++++++++++++
 tb/tb_stack_unit_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_unit_arbiter.sv
// Round-robin two-requester front end for the stack arithmetic unit: one command in flight at a time.
// Optional `define STACK_ARB_LOCK_EN lets the current winner hold priority via req_lock.
//
// state | meaning
// IDLE  | wait for a command, grant one requester
// ISSUE | check the depth precondition, pulse au_en if it holds
// WAIT  | count out the unit's latency
// RESP  | one-cycle response to the owner
module stack_unit_arbiter #(
  parameter int GAP_NORMAL = 2,
  parameter int GAP_LONG   = 3,
  parameter int DEPTH_MAX  = 1000
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [1:0]  req_push,
  input  logic [5:0]  req_op,
  input  logic [31:0] req_d,
  input  logic [1:0]  req_lock,
  output logic        au_push,
  output logic        au_en,
  output logic [2:0]  au_op,
  output logic [15:0] au_d,
  input  logic [15:0] au_out,
  input  logic [9:0]  au_cnt,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [15:0] rsp_data,
  output logic [9:0]  rsp_cnt,
  output logic        rsp_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic        rr_q, rr_d;
  logic        push_q, push_d;
  logic [2:0]  op_q, op_d;
  logic [15:0] d_q, d_d;
  logic        id_q, id_d;
  logic        err_q, err_d;
  logic [7:0]  wcnt_q, wcnt_d;

  logic        win;
  logic        lock_hold;
  logic        pass;
  logic        long_op;
  logic [7:0]  gap_m1;

  assign win = req_valid[rr_q] ? rr_q : ~rr_q;

`ifdef STACK_ARB_LOCK_EN
  assign lock_hold = win ? req_lock[1] : req_lock[0];
`else
  logic unused_lock;
  assign unused_lock = ^req_lock;
  assign lock_hold   = 1'b0;
`endif

  assign long_op = ~push_q & ((op_q == 3'd4) | (op_q == 3'd5));
  assign gap_m1  = long_op ? 8'(GAP_LONG - 1) : 8'(GAP_NORMAL - 1);

  always_comb begin
    pass = 1'b0;
    if (push_q) begin
      pass = ({1'b0, au_cnt} < 11'(DEPTH_MAX));
    end else begin
      case (op_q)
        3'd2, 3'd3, 3'd4: pass = (au_cnt > 10'd1);
        3'd5:             pass = ({6'b0, au_cnt} > au_out);
        default:          pass = (au_cnt != 10'd0);
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    push_d    = push_q;
    op_d      = op_q;
    d_d       = d_q;
    id_d      = id_q;
    err_d     = err_q;
    wcnt_d    = wcnt_q;
    req_ready = 2'b00;
    au_en     = 1'b0;
    au_push   = 1'b0;
    au_op     = 3'd0;
    au_d      = 16'd0;
    rsp_valid = 1'b0;
    rsp_id    = 1'b0;
    rsp_data  = 16'd0;
    rsp_cnt   = 10'd0;
    rsp_err   = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          req_ready = win ? 2'b10 : 2'b01;
          push_d    = win ? req_push[1] : req_push[0];
          op_d      = win ? req_op[5:3] : req_op[2:0];
          d_d       = win ? req_d[31:16] : req_d[15:0];
          id_d      = win;
          err_d     = 1'b0;
          rr_d      = lock_hold ? win : ~win;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (pass) begin
          au_en   = 1'b1;
          au_push = push_q;
          au_op   = op_q;
          au_d    = d_q;
          wcnt_d  = gap_m1;
          state_d = (gap_m1 == 8'd0) ? RESP : WAIT;
        end else begin
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      WAIT: begin
        wcnt_d = wcnt_q - 8'd1;
        if (wcnt_q <= 8'd1) state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_id    = id_q;
        rsp_data  = au_out;
        rsp_cnt   = au_cnt;
        rsp_err   = err_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      push_q  <= 1'b0;
      op_q    <= 3'd0;
      d_q     <= 16'd0;
      id_q    <= 1'b0;
      err_q   <= 1'b0;
      wcnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      push_q  <= push_d;
      op_q    <= op_d;
      d_q     <= d_d;
      id_q    <= id_d;
      err_q   <= err_d;
      wcnt_q  <= wcnt_d;
    end
  end

endmodule

// File: tb/tb_stack_unit_arbiter.sv
// Directed bench for stack_unit_arbiter with a behavioural stack unit model.
// Expected grant order of the lock test follows STACK_ARB_LOCK_EN.
module tb_stack_unit_arbiter;

  logic        clk = 1'b0;
  logic        nrst = 1'b1;
  logic [1:0]  req_valid = '0, req_ready, req_push = '0, req_lock = '0;
  logic [5:0]  req_op = '0;
  logic [31:0] req_d = '0;
  logic        au_push, au_en;
  logic [2:0]  au_op;
  logic [15:0] au_d, au_out;
  logic [9:0]  au_cnt;
  logic        rsp_valid, rsp_id, rsp_err;
  logic [15:0] rsp_data;
  logic [9:0]  rsp_cnt;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  stack_unit_arbiter dut (
    .clk(clk), .nrst(nrst),
    .req_valid(req_valid), .req_ready(req_ready), .req_push(req_push),
    .req_op(req_op), .req_d(req_d), .req_lock(req_lock),
    .au_push(au_push), .au_en(au_en), .au_op(au_op), .au_d(au_d),
    .au_out(au_out), .au_cnt(au_cnt),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_cnt(rsp_cnt), .rsp_err(rsp_err)
  );

  // stack unit model; pl_* lets the bench preset depth and the two bottom entries
  logic [15:0] mem [0:1023];
  logic [9:0]  m_cnt;
  logic        pl_en = 1'b0;
  logic [9:0]  pl_cnt = '0;
  logic [15:0] pl_m0 = '0, pl_m1 = '0;

  assign au_out = (m_cnt == 10'd0) ? 16'h0 : mem[m_cnt - 10'd1];
  assign au_cnt = m_cnt;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m_cnt <= '0;
    end else if (pl_en) begin
      m_cnt  <= pl_cnt;
      mem[0] <= pl_m0;
      mem[1] <= pl_m1;
    end else if (au_en) begin
      if (au_push) begin
        mem[m_cnt] <= au_d;
        m_cnt      <= m_cnt + 10'd1;
      end else begin
        case (au_op)
          3'd0: begin mem[m_cnt] <= au_out; m_cnt <= m_cnt + 10'd1; end
          3'd1: m_cnt <= m_cnt - 10'd1;
          3'd2: begin mem[m_cnt - 10'd2] <= mem[m_cnt - 10'd2] + au_out; m_cnt <= m_cnt - 10'd1; end
          3'd3: begin mem[m_cnt - 10'd2] <= mem[m_cnt - 10'd2] - au_out; m_cnt <= m_cnt - 10'd1; end
          3'd4: begin mem[m_cnt - 10'd2] <= au_out; mem[m_cnt - 10'd1] <= mem[m_cnt - 10'd2]; end
          3'd5: mem[m_cnt - 10'd1] <= mem[au_out[9:0]];
          default: ;
        endcase
      end
    end
  end

  function automatic logic [63:0] all_outs();
    return {12'b0, req_ready, au_push, au_en, au_op, au_d,
            rsp_valid, rsp_id, rsp_data, rsp_cnt, rsp_err};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    req_valid = '0;
    req_lock = '0;
    #1 chk("rst_outs", all_outs(), 64'd0);
    @(posedge clk); #1;
    nrst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic preload(input logic [9:0] c, input logic [15:0] m0, input logic [15:0] m1);
    pl_cnt = c; pl_m0 = m0; pl_m1 = m1; pl_en = 1'b1;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // one command from one requester; lat = expected GAP, 0 for a refused command
  task automatic issue(input int id, input logic push, input logic [2:0] op, input logic [15:0] d,
                       input int lat, input logic [15:0] ed, input logic [9:0] ec, input logic ee);
    int last;
    req_valid = (id == 1) ? 2'b10 : 2'b01;
    if (id == 1) begin
      req_push = {push, ~push}; req_op = {op, ~op}; req_d = {d, ~d};
    end else begin
      req_push = {~push, push}; req_op = {~op, op}; req_d = {~d, d};
    end
    #1 chk("ready", req_ready, (id == 1) ? 64'd2 : 64'd1);
    @(posedge clk); #1;
    req_valid = '0; req_push = ~req_push; req_op = ~req_op; req_d = ~req_d;
    if (lat != 0) begin
      chk("au_issue", {au_en, au_push, au_op, au_d}, {1'b1, push, op, d});
    end else begin
      chk("au_quiet", {au_en, au_push, au_op, au_d}, 64'd0);
    end
    last = (lat == 0) ? 2 : 1 + lat;
    for (int k = 2; k <= last; k++) begin
      @(posedge clk); #1;
      if (k < last) chk("early_rsp", rsp_valid, 1'b0);
    end
    chk("rsp", {rsp_valid, rsp_id, rsp_data, rsp_cnt, rsp_err},
        {1'b1, (id == 1), ed, ec, ee});
    @(posedge clk); #1;
  endtask

  task automatic wait_grant(output int who, output int n);
    logic found;
    found = 1'b0;
    who = -1;
    n = -1;
    for (int i = 0; i < 12 && !found; i++) begin
      #1;
      if (req_ready != 2'b00) begin
        found = 1'b1;
        who = int'(req_ready[1]);
        n = i;
      end
      @(posedge clk); #1;
    end
    chk("grant_seen", found, 1'b1);
  endtask

  int who, n, n0;
  int exp_g [4];

  initial begin
`ifdef STACK_ARB_LOCK_EN
    exp_g = '{0, 0, 0, 1};
`else
    exp_g = '{0, 1, 0, 1};
`endif
    #2;
    // single push after reset
    do_reset();
    issue(0, 1'b1, 3'd0, 16'h0005, 2, 16'h0005, 10'd1, 1'b0);

    // both requesters contending, then add
    do_reset();
    req_valid = 2'b11; req_push = 2'b11; req_op = '0; req_d = {16'd4, 16'd3};
    wait_grant(who, n);
    chk("first_grant", who, 0);
    chk("first_wait", n, 0);
    req_valid = 2'b10;
    wait_grant(who, n);
    chk("second_grant", who, 1);
    chk("second_wait", n, 3);
    req_valid = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("second_rsp", {rsp_valid, rsp_id, rsp_data, rsp_cnt}, {1'b1, 1'b1, 16'd4, 10'd2});
    @(posedge clk); #1;
    issue(0, 1'b0, 3'd2, 16'h0, 2, 16'd7, 10'd1, 1'b0);

    // swap uses the long gap
    do_reset();
    issue(0, 1'b1, 3'd0, 16'd3, 2, 16'd3, 10'd1, 1'b0);
    issue(1, 1'b1, 3'd0, 16'd4, 2, 16'd4, 10'd2, 1'b0);
    issue(1, 1'b0, 3'd4, 16'h0, 3, 16'd3, 10'd2, 1'b0);

    // depth preconditions
    do_reset();
    issue(0, 1'b0, 3'd1, 16'h0, 0, 16'd0, 10'd0, 1'b1);
    issue(0, 1'b1, 3'd0, 16'd8, 2, 16'd8, 10'd1, 1'b0);
    issue(1, 1'b0, 3'd3, 16'h0, 0, 16'd8, 10'd1, 1'b1);
    issue(0, 1'b0, 3'd0, 16'h0, 2, 16'd8, 10'd2, 1'b0);

    // full-stack boundary
    preload(10'd999, 16'h1, 16'h2);
    issue(0, 1'b1, 3'd0, 16'h0077, 2, 16'h0077, 10'd1000, 1'b0);
    issue(1, 1'b1, 3'd0, 16'h0088, 0, 16'h0077, 10'd1000, 1'b1);

    // load: depth must exceed top-of-stack
    preload(10'd2, 16'd9, 16'd0);
    issue(0, 1'b0, 3'd5, 16'h0, 3, 16'd9, 10'd2, 1'b0);
    preload(10'd2, 16'd9, 16'd1);
    issue(1, 1'b0, 3'd5, 16'h0, 3, 16'd1, 10'd2, 1'b0);
    preload(10'd2, 16'd9, 16'd2);
    issue(0, 1'b0, 3'd5, 16'h0, 0, 16'd2, 10'd2, 1'b1);

    // reset during WAIT of a push
    do_reset();
    req_valid = 2'b01; req_push = 2'b01; req_op = '0; req_d = {16'h0, 16'h0055};
    #1 chk("pre_abort_ready", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    nrst = 1'b0;
    #1 chk("abort_outs", all_outs(), 64'd0);
    @(posedge clk); #1;
    nrst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("abort_no_rsp", rsp_valid, 1'b0);
      @(posedge clk); #1;
    end
    req_valid = 2'b11; req_push = 2'b11;
    #1 chk("abort_rr", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // lock / alternation under contention
    do_reset();
    req_valid = 2'b11; req_push = 2'b11; req_op = '0; req_d = {16'h00b1, 16'h00a0};
    req_lock = 2'b01;
    n0 = 0;
    for (int g = 0; g < 4; g++) begin
      wait_grant(who, n);
      chk("lock_seq", who, exp_g[g]);
      if (who == 0) n0++;
      if (n0 == 3) req_valid[0] = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
    end
    req_valid = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
